// File: rtl/data_mem_ctrl.sv
// RV32I load/store sequencer for the core's data AXI4 master port.
// One single-beat read or write per request; formats stores and extends loads.
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE      | waiting for a memory-stage request
// RD_ADDR   | ARVALID asserted, waiting for ARREADY
// RD_DATA   | RREADY asserted, waiting for RVALID
// WR_REQ    | AWVALID/WVALID asserted until each handshakes
// WR_RESP   | BREADY asserted, waiting for BVALID
// DONE      | one-cycle completion pulse back to the pipeline
module data_mem_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            REQ_VALID,
    input  logic                            REQ_WE,
    input  logic [2:0]                      REQ_FUNCT3,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   REQ_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   REQ_WDATA,
    output logic                            MEM_WAIT,
    output logic                            RESP_VALID,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   RESP_RDATA,
    output logic                            RESP_ERR,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]                      M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE
    } state_t;

    state_t state, state_n;

    logic [2:0]                    funct3_q;
    logic [1:0]                    offset_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] axaddr_q;
    logic [3:0]                    wstrb_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
    logic                          err_q;
    logic                          aw_done;
    logic                          w_done;

    logic                          req_illegal;
    logic                          f3_bad;
    logic                          misaligned;
    logic [3:0]                    wstrb_fmt;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_fmt;
    logic [7:0]                    byte_sel;
    logic [15:0]                   half_sel;
    logic [C_M_AXI_DATA_WIDTH-1:0] load_ext;

    // RLAST carries no information for single-beat reads.
    logic unused_rlast;
    assign unused_rlast = M_AXI_RLAST;

    always_comb begin
        f3_bad     = 1'b0;
        misaligned = 1'b0;
        wstrb_fmt  = 4'b1111;
        wdata_fmt  = REQ_WDATA;
        if (REQ_WE) begin
            f3_bad = (REQ_FUNCT3 >= 3'b011);
        end else begin
            f3_bad = (REQ_FUNCT3 == 3'b011) || (REQ_FUNCT3 == 3'b110) ||
                     (REQ_FUNCT3 == 3'b111);
        end
        if (REQ_FUNCT3[1:0] == 2'b01) begin
            misaligned = REQ_ADDR[0];
        end else if (REQ_FUNCT3[1:0] == 2'b10) begin
            misaligned = (REQ_ADDR[1:0] != 2'b00);
        end
        case (REQ_FUNCT3[1:0])
            2'b00: begin
                wstrb_fmt = 4'b0001 << REQ_ADDR[1:0];
                wdata_fmt = {4{REQ_WDATA[7:0]}};
            end
            2'b01: begin
                wstrb_fmt = 4'b0011 << {REQ_ADDR[1], 1'b0};
                wdata_fmt = {2{REQ_WDATA[15:0]}};
            end
            default: begin
                wstrb_fmt = 4'b1111;
                wdata_fmt = REQ_WDATA;
            end
        endcase
        req_illegal = f3_bad || misaligned;
    end

    always_comb begin
        byte_sel = M_AXI_RDATA[7:0];
        case (offset_q)
            2'd1:    byte_sel = M_AXI_RDATA[15:8];
            2'd2:    byte_sel = M_AXI_RDATA[23:16];
            2'd3:    byte_sel = M_AXI_RDATA[31:24];
            default: byte_sel = M_AXI_RDATA[7:0];
        endcase
        half_sel = offset_q[1] ? M_AXI_RDATA[31:16] : M_AXI_RDATA[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = M_AXI_RDATA;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        MEM_WAIT      = 1'b0;
        RESP_VALID    = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state)
            IDLE: begin
                MEM_WAIT = REQ_VALID;
                if (REQ_VALID) begin
                    if (req_illegal)  state_n = DONE;
                    else if (REQ_WE)  state_n = WR_REQ;
                    else              state_n = RD_ADDR;
                end
            end
            RD_ADDR: begin
                MEM_WAIT      = 1'b1;
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) state_n = RD_DATA;
            end
            RD_DATA: begin
                MEM_WAIT     = 1'b1;
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) state_n = DONE;
            end
            WR_REQ: begin
                MEM_WAIT      = 1'b1;
                M_AXI_AWVALID = !aw_done;
                M_AXI_WVALID  = !w_done;
                if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY))
                    state_n = WR_RESP;
            end
            WR_RESP: begin
                MEM_WAIT     = 1'b1;
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_n = DONE;
            end
            DONE: begin
                RESP_VALID = 1'b1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            funct3_q <= '0;
            offset_q <= '0;
            axaddr_q <= '0;
            wstrb_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_VALID) begin
                        funct3_q <= REQ_FUNCT3;
                        offset_q <= REQ_ADDR[1:0];
                        axaddr_q <= {REQ_ADDR[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
                        wstrb_q  <= wstrb_fmt;
                        wdata_q  <= wdata_fmt;
                        err_q    <= req_illegal;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        if (req_illegal) rdata_q <= '0;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        err_q   <= (M_AXI_RRESP != 2'b00);
                        rdata_q <= (M_AXI_RRESP != 2'b00) ? '0 : load_ext;
                    end
                end
                WR_REQ: begin
                    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
                    if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        err_q   <= (M_AXI_BRESP != 2'b00);
                        rdata_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RESP_RDATA   = rdata_q;
    assign RESP_ERR     = RESP_VALID && err_q;
    assign M_AXI_AWADDR = axaddr_q;
    assign M_AXI_ARADDR = axaddr_q;
    assign M_AXI_WDATA  = wdata_q;
    assign M_AXI_WSTRB  = wstrb_q;
    assign M_AXI_WLAST  = M_AXI_WVALID;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: vector table through an AXI slave model, response
// scoreboard, plus a reset-during-read sequence.
module tb_data_mem_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ_VALID, REQ_WE;
    logic [2:0]  REQ_FUNCT3;
    logic [31:0] REQ_ADDR, REQ_WDATA;
    logic        MEM_WAIT, RESP_VALID, RESP_ERR;
    logic [31:0] RESP_RDATA;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [3:0]  M_AXI_WSTRB;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    data_mem_ctrl dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE), .REQ_FUNCT3(REQ_FUNCT3),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .MEM_WAIT(MEM_WAIT), .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA),
        .RESP_ERR(RESP_ERR),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] srdata;
        logic [1:0]  sresp;
        int          aw_dly;
        int          w_dly;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic        exp_bus;
        logic [31:0] exp_axaddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    int    n_checks = 0;
    int    n_errors = 0;
    resp_t exp_q[$];
    vec_t  vecs[$];

    logic        auto_slave = 1'b1;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;
    int          aw_dly = 0, w_dly = 0, aw_cnt = 0, w_cnt = 0;
    int          ar_cyc, aw_cyc, w_cyc, viol = 0, wlast_bad = 0;
    logic [31:0] ar_addr, aw_addr, w_data;
    logic [3:0]  w_strb;
    logic        p_arv = 0, p_awv = 0, p_wv = 0;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] srdata,
                                input logic [1:0] sresp, input int aw, input int w,
                                input logic err, input logic [31:0] rdata, input int lat,
                                input logic bus, input logic [31:0] axaddr,
                                input logic [3:0] strb, input logic [31:0] wd);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.srdata = srdata;
        v.sresp = sresp; v.aw_dly = aw; v.w_dly = w; v.exp_err = err; v.exp_rdata = rdata;
        v.exp_lat = lat; v.exp_bus = bus; v.exp_axaddr = axaddr; v.exp_strb = strb;
        v.exp_wdata = wd;
        return v;
    endfunction

    // Slave model and monitor: samples at negedge, then drives new ready/valid.
    initial begin
        resp_t r;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 0;
        forever begin
            @(negedge CLK);
            if (RST || !auto_slave) begin
                p_arv = 0; p_awv = 0; p_wv = 0;
                if (auto_slave) begin
                    M_AXI_ARREADY = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
                    M_AXI_RVALID = 0; M_AXI_BVALID = 0; aw_cnt = 0; w_cnt = 0;
                end
            end else begin
                if (p_arv && (!M_AXI_ARVALID || M_AXI_ARADDR !== p_araddr)) viol++;
                if (p_awv && (!M_AXI_AWVALID || M_AXI_AWADDR !== p_awaddr)) viol++;
                if (p_wv && (!M_AXI_WVALID || M_AXI_WDATA !== p_wdata || M_AXI_WSTRB !== p_wstrb))
                    viol++;
                if (M_AXI_ARVALID) begin ar_cyc++; ar_addr = M_AXI_ARADDR; end
                if (M_AXI_AWVALID) begin aw_cyc++; aw_addr = M_AXI_AWADDR; end
                if (M_AXI_WVALID) begin
                    w_cyc++; w_data = M_AXI_WDATA; w_strb = M_AXI_WSTRB;
                    if (M_AXI_WLAST !== 1'b1) wlast_bad++;
                end
                M_AXI_ARREADY = M_AXI_ARVALID;
                if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_cnt >= aw_dly); aw_cnt++; end
                else begin M_AXI_AWREADY = 0; aw_cnt = 0; end
                if (M_AXI_WVALID) begin M_AXI_WREADY = (w_cnt >= w_dly); w_cnt++; end
                else begin M_AXI_WREADY = 0; w_cnt = 0; end
                M_AXI_RVALID = M_AXI_RREADY; M_AXI_RDATA = s_rdata;
                M_AXI_RRESP = s_rresp; M_AXI_RLAST = M_AXI_RREADY;
                M_AXI_BVALID = M_AXI_BREADY; M_AXI_BRESP = s_bresp;
                p_arv = M_AXI_ARVALID && !M_AXI_ARREADY; p_araddr = M_AXI_ARADDR;
                p_awv = M_AXI_AWVALID && !M_AXI_AWREADY; p_awaddr = M_AXI_AWADDR;
                p_wv  = M_AXI_WVALID && !M_AXI_WREADY;
                p_wdata = M_AXI_WDATA; p_wstrb = M_AXI_WSTRB;
            end
            if (!RST && RESP_VALID) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_resp", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    check("sb_resp_err", RESP_ERR, r.err);
                    check("sb_resp_rdata", RESP_RDATA, r.rdata);
                end
            end
        end
    end

    task automatic run_vec(input string p, input vec_t v);
        int    cyc;
        logic  mw_ok;
        resp_t r;
        @(negedge CLK);
        s_rdata = v.srdata; s_rresp = v.sresp; s_bresp = v.sresp;
        aw_dly = v.aw_dly; w_dly = v.w_dly;
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
        ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;
        REQ_VALID = 1; REQ_WE = v.we; REQ_FUNCT3 = v.f3; REQ_ADDR = v.addr; REQ_WDATA = v.wdata;
        r.err = v.exp_err; r.rdata = v.exp_rdata;
        exp_q.push_back(r);
        #1;
        mw_ok = (MEM_WAIT === 1'b1);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
            if (!RESP_VALID && MEM_WAIT !== 1'b1) mw_ok = 0;
            if (RESP_VALID && MEM_WAIT !== 1'b0) mw_ok = 0;
        end while (!RESP_VALID && cyc < 40);
        check({p, "_latency"}, cyc, v.exp_lat);
        check({p, "_mem_wait"}, mw_ok, 1);
        if (!v.exp_bus) begin
            check({p, "_no_bus"}, ar_cyc + aw_cyc + w_cyc, 0);
        end else if (!v.we) begin
            check({p, "_araddr"}, ar_addr, v.exp_axaddr);
            check({p, "_ar_cycles"}, ar_cyc, 1);
            check({p, "_no_write"}, aw_cyc + w_cyc, 0);
        end else begin
            check({p, "_awaddr"}, aw_addr, v.exp_axaddr);
            check({p, "_wstrb"}, w_strb, v.exp_strb);
            check({p, "_wdata"}, w_data, v.exp_wdata);
            check({p, "_aw_cycles"}, aw_cyc, v.aw_dly + 1);
            check({p, "_w_cycles"}, w_cyc, v.w_dly + 1);
            check({p, "_no_read"}, ar_cyc, 0);
        end
        // REQ_VALID is still high through DONE; it must not start a new access.
        @(negedge CLK);
        check({p, "_single_pulse"}, RESP_VALID, 0);
        check({p, "_rdata_hold"}, RESP_RDATA, v.exp_rdata);
        check({p, "_done_ignores_req"}, M_AXI_ARVALID | M_AXI_AWVALID, 0);
        REQ_VALID = 0;
    endtask

    task automatic reset_mid_read();
        int cyc;
        @(negedge CLK);
        auto_slave = 0;
        M_AXI_ARREADY = 0; M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        M_AXI_RVALID = 0; M_AXI_BVALID = 0;
        @(negedge CLK);
        M_AXI_ARREADY = 1;
        REQ_VALID = 1; REQ_WE = 0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h700;
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (M_AXI_RREADY !== 1'b1 && cyc < 10);
        check("rst_reached_rd_data", M_AXI_RREADY, 1);
        M_AXI_ARREADY = 0; M_AXI_RVALID = 1; M_AXI_RDATA = 32'h5555_AAAA; M_AXI_RRESP = 0;
        RST = 1; REQ_VALID = 0;
        @(negedge CLK);
        check("rst_rready_low", M_AXI_RREADY, 0);
        check("rst_mem_wait_low", MEM_WAIT, 0);
        check("rst_resp_rdata_zero", RESP_RDATA, 0);
        check("rst_all_outputs_zero",
              |{MEM_WAIT, RESP_VALID, RESP_RDATA, RESP_ERR, M_AXI_AWADDR, M_AXI_AWVALID,
                M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
                M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        RST = 0; M_AXI_RVALID = 0;
        @(negedge CLK);
        auto_slave = 1;
    endtask

    initial begin
        RST = 1; REQ_VALID = 0; REQ_WE = 0; REQ_FUNCT3 = 0; REQ_ADDR = 0; REQ_WDATA = 0;
        repeat (3) @(negedge CLK);
        check("reset_outputs_zero",
              |{MEM_WAIT, RESP_VALID, RESP_RDATA, RESP_ERR, M_AXI_AWADDR, M_AXI_AWVALID,
                M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY,
                M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY}, 0);
        check("reset_resp_rdata", RESP_RDATA, 0);
        RST = 0;

        // we f3 addr wdata srdata sresp aw w | err rdata lat bus axaddr strb wdata
        vecs.push_back(mk(0, 3'b010, 32'h104, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF, 3, 1, 32'h104, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h203, 0, 32'h80FF0000, 0, 0, 0, 0, 32'hFFFFFF80, 3, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h203, 0, 32'h80FF0000, 0, 0, 0, 0, 32'h00000080, 3, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h202, 0, 32'h80FF0000, 0, 0, 0, 0, 32'hFFFF80FF, 3, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 3'b101, 32'h200, 0, 32'h1234F00D, 0, 0, 0, 0, 32'h0000F00D, 3, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h200, 0, 32'h1234F00D, 0, 0, 0, 0, 32'hFFFFF00D, 3, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 3'b000, 32'h201, 0, 32'h1234F00D, 0, 0, 0, 0, 32'hFFFFFFF0, 3, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 3'b100, 32'h200, 0, 32'h1234F00D, 0, 0, 0, 0, 32'h0000000D, 3, 1, 32'h200, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h101, 0, 32'h11111111, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h302, 32'h1234ABCD, 0, 0, 3, 0, 0, 32'h0, 6, 1, 32'h300, 4'b1100, 32'hABCDABCD));
        vecs.push_back(mk(1, 3'b000, 32'h101, 32'h000000A5, 0, 0, 0, 2, 0, 32'h0, 5, 1, 32'h100, 4'b0010, 32'hA5A5A5A5));
        vecs.push_back(mk(1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 0, 0, 0, 0, 32'h0, 3, 1, 32'h400, 4'b1111, 32'hCAFEF00D));
        vecs.push_back(mk(1, 3'b000, 32'h003, 32'h11223344, 0, 0, 1, 1, 0, 32'h0, 4, 1, 32'h000, 4'b1000, 32'h44444444));
        vecs.push_back(mk(1, 3'b011, 32'h500, 32'h12345678, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h10C, 0, 32'h0BADF00D, 0, 0, 0, 0, 32'h0BADF00D, 3, 1, 32'h10C, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'h404, 32'h5A5A0001, 0, 2'b10, 0, 0, 1, 32'h0, 3, 1, 32'h404, 4'b1111, 32'h5A5A0001));
        vecs.push_back(mk(0, 3'b010, 32'h108, 0, 32'h12345678, 2'b11, 0, 0, 1, 32'h0, 3, 1, 32'h108, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h201, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b110, 32'h600, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'h303, 32'hFFFF, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b010, 32'h110, 0, 32'hA5A5C3C3, 0, 0, 0, 0, 32'hA5A5C3C3, 3, 1, 32'h110, 0, 0));

        foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

        reset_mid_read();
        run_vec("post_rst", mk(0, 3'b100, 32'h702, 0, 32'h00C30000, 0, 0, 0, 0, 32'h000000C3, 3, 1, 32'h700, 0, 0));

        repeat (2) @(negedge CLK);
        check("axi_valid_stable_until_ready", viol, 0);
        check("wlast_with_wvalid", wlast_bad, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
